sy_ppl_fpu_seq: RTL

SY_PPL_FPU_SEQ -- requirements
Module: sy_ppl_fpu_seq

---
 rtl/sy_ppl_fpu_seq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sy_ppl_fpu_seq.sv
// -----------------------------------------------------------------------------
// sy_ppl_fpu_seq
//   Sequencer between instruction decode and a pipelined FPU datapath.
//   It resolves the rounding mode, rejects reserved rounding modes, and issues
//   ops to the FPU. It tracks the destination tags of in-flight ops in an
//   in-order FIFO and produces a registered writeback and an fflags accrual
//   for every completion. A pipeline flush cannot kill ops that the FPU has
//   already accepted, so the sequencer counts them and silently discards
//   their late results in the DRAIN state.
//
// Parameters
//   DEPTH  maximum FPU ops in flight (2..8)
//   RDW    destination register tag width
//   FLEN   FPU result width
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   flush_i                   pipeline flush
//   req_valid_i/req_ready_o   decode request handshake
//   req_rd_i, req_rm_i        request tag and instruction rounding mode
//   csr_frm_i                 CSR frm, used when req_rm_i is dynamic (3'b111)
//   fpu_valid_o/fpu_ready_i   issue handshake to the FPU datapath
//   fpu_rm_o                  resolved rounding mode (combinational)
//   fpu_result_valid_i        in-order completion strobe
//   fpu_result_i/fpu_status_i completion data and fflags
//   wb_valid_o/wb_rd_o/wb_data_o    registered writeback
//   fflags_valid_o/fflags_o   registered fflags accrual
//   illegal_rm_o              pulse: request rejected for a reserved rm
//   busy_o                    ops tracked or drain in progress
// -----------------------------------------------------------------------------
module sy_ppl_fpu_seq #(
  parameter int DEPTH = 4,
  parameter int RDW   = 5,
  parameter int FLEN  = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [RDW-1:0]  req_rd_i,
  input  logic [2:0]      req_rm_i,
  input  logic [2:0]      csr_frm_i,
  output logic            fpu_valid_o,
  input  logic            fpu_ready_i,
  output logic [2:0]      fpu_rm_o,
  input  logic            fpu_result_valid_i,
  input  logic [FLEN-1:0] fpu_result_i,
  input  logic [4:0]      fpu_status_i,
  output logic            wb_valid_o,
  output logic [RDW-1:0]  wb_rd_o,
  output logic [FLEN-1:0] wb_data_o,
  output logic            fflags_valid_o,
  output logic [4:0]      fflags_o,
  output logic            illegal_rm_o,
  output logic            busy_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count, count_next;
  logic [CW-1:0]   discard_cnt, discard_next;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [RDW-1:0]  tag_mem [DEPTH];

  logic [2:0]      rm_res;
  logic            rm_legal;
  logic            issue;
  logic            pop;
  logic            reject;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Rounding mode resolution: 3'b111 selects the CSR frm; 101/110/111 after
  // resolution are reserved encodings.
  assign rm_res   = (req_rm_i == 3'b111) ? csr_frm_i : req_rm_i;
  assign rm_legal = (rm_res < 3'd5);
  assign fpu_rm_o = rm_res;

  assign issue  = fpu_valid_o & fpu_ready_i;
  assign busy_o = (count != '0) | (state == DRAIN);

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next   = state;
    discard_next = discard_cnt;
    fpu_valid_o  = 1'b0;
    req_ready_o  = 1'b0;
    reject       = 1'b0;
    pop          = 1'b0;
    unique case (state)
      RUN: begin
        fpu_valid_o = req_valid_i & (count < DEPTH_C) & rm_legal & ~flush_i;
        // A reserved rm is consumed (ready) without reaching the FPU.
        req_ready_o = rm_legal ? (fpu_valid_o & fpu_ready_i)
                               : (req_valid_i & ~flush_i);
        reject      = req_valid_i & ~rm_legal & ~flush_i;
        // A result in the flush cycle belongs to a killed op: no pop.
        pop         = fpu_result_valid_i & (count != '0) & ~flush_i;
        if (flush_i) begin
          // Ops still owed by the FPU, minus the one completing right now.
          discard_next = count - ((fpu_result_valid_i && (count != '0)) ? ONE_C : '0);
          if (discard_next != '0) state_next = DRAIN;
        end
      end
      DRAIN: begin
        // A flush here changes nothing: the FIFO is already empty and the
        // owed-result count stays valid.
        if (fpu_result_valid_i) begin
          discard_next = discard_cnt - ONE_C;
          if (discard_cnt == ONE_C) state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    count_next = count;
    unique case ({issue, pop})
      2'b10:   count_next = count + ONE_C;
      2'b01:   count_next = count - ONE_C;
      default: count_next = count;
    endcase
    if (flush_i) count_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= RUN;
      count       <= '0;
      discard_cnt <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      discard_cnt <= discard_next;
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (issue) wr_ptr <= bump(wr_ptr);
        if (pop)   rd_ptr <= bump(rd_ptr);
      end
    end
  end

  // NOTE: tag storage has no reset; an entry is only read after it was
  // written, and the pointers/count decide which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (issue) tag_mem[wr_ptr] <= req_rd_i;
  end

  // Registered writeback, fflags accrual and the illegal-rm pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_o     <= 1'b0;
      wb_rd_o        <= '0;
      wb_data_o      <= '0;
      fflags_valid_o <= 1'b0;
      fflags_o       <= '0;
      illegal_rm_o   <= 1'b0;
    end else begin
      wb_valid_o     <= pop;
      fflags_valid_o <= pop;
      illegal_rm_o   <= reject;
      if (pop) begin
        wb_rd_o   <= tag_mem[rd_ptr];
        wb_data_o <= fpu_result_i;
        fflags_o  <= fpu_status_i;
      end
    end
  end

endmodule
